seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 85 ++++++++
 tb/tb_seg7_scan_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit time-multiplexed common-anode 7-seg scanner with per-frame snapshot.
// Define SEG7_LZ_BLANK_EN to suppress leading zeros on digits 7..1.
module seg7_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  dig_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW:0] BL = (CW+1)'(BLANK);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    dp_q, dp_d, en_q, en_d, an_d, seg_d;
  logic          wrap, snap, drive, lz, lit;
  logic [3:0]    nib;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction
  // Decode from the next shadow value so a snapshot is usable in the same cycle (matters for BLANK=0).
  always_comb begin
    wrap   = cnt_q == CW'(DIV - 1);
    snap   = idx_q == '0 && cnt_q == '0;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 3'd1 : idx_q;
    data_d = snap ? data : data_q;
    dp_d   = snap ? dp_in : dp_q;
    en_d   = snap ? dig_en : en_q;
    nib    = data_d[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
    lz     = idx_q != 3'd0 && (data_d >> {idx_q, 2'b00}) == 32'd0;
`else
    lz     = 1'b0;
`endif
    drive  = ({1'b0, cnt_q} + (CW+1)'(1)) > BL;
    lit    = drive && en_d[idx_q] && !lz;
    an_d   = lit ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d  = lit ? {~dp_d[idx_q], decode(nib)} : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      dp_q       <= '0;
      en_q       <= '0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      dp_q       <= dp_d;
      en_q       <= en_d;
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= wrap && idx_q == 3'd7;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: random and directed stimulus on two scanner configurations against a frame-position model.
module tb_seg7_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0] dp_in = '0, dig_en = '0;
  logic [7:0] an_a, seg_a, an_b, seg_b;
  logic fd_a, fd_b;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.DIV(4), .BLANK(1)) u_a (.clk(clk), .rst(rst), .data(data), .dp_in(dp_in),
    .dig_en(dig_en), .an(an_a), .seg(seg_a), .frame_done(fd_a));
  seg7_scan_ctrl #(.DIV(2), .BLANK(0)) u_b (.clk(clk), .rst(rst), .data(data), .dp_in(dp_in),
    .dig_en(dig_en), .an(an_b), .seg(seg_b), .frame_done(fd_b));
  typedef struct {
    int div, blank, p;
    logic [31:0] d;
    logic [7:0] dp, en, an, seg;
    logic fd;
  } mdl_t;
  mdl_t ma, mb;
  logic [7:0] segtbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // Model: position within the frame p = cycles since reset release mod 8*div.
  function automatic mdl_t step(input mdl_t m, input logic r, input logic [31:0] d,
                                input logic [7:0] dp, input logic [7:0] en);
    int slot, off;
    logic on, lead;
    if (r) begin
      m.p = 0; m.d = '0; m.dp = '0; m.en = '0; m.an = 8'hFF; m.seg = 8'hFF; m.fd = 1'b0;
      return m;
    end
    if (m.p == 0) begin
      m.d = d; m.dp = dp; m.en = en;
    end
    slot = m.p / m.div;
    off  = m.p % m.div;
`ifdef SEG7_LZ_BLANK_EN
    lead = slot != 0 && (m.d >> (4 * slot)) == 32'd0;
`else
    lead = 1'b0;
`endif
    on    = off >= m.blank && m.en[slot] && !lead;
    m.an  = on ? (8'hFF ^ (8'h01 << slot)) : 8'hFF;
    m.seg = on ? (segtbl[(m.d >> (4 * slot)) & 32'hF] & (m.dp[slot] ? 8'h7F : 8'hFF)) : 8'hFF;
    m.fd  = m.p == 8 * m.div - 1;
    m.p   = (m.p + 1) % (8 * m.div);
    return m;
  endfunction
  task automatic cyc(input logic r, input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    rst = r; data = d; dp_in = p; dig_en = e;
    ma = step(ma, r, d, p, e);
    mb = step(mb, r, d, p, e);
    @(negedge clk);
    chk("an_a", an_a, ma.an);
    chk("seg_a", seg_a, ma.seg);
    chk("fd_a", fd_a, ma.fd);
    chk("an_b", an_b, mb.an);
    chk("seg_b", seg_b, mb.seg);
    chk("fd_b", fd_b, mb.fd);
    chk("onehot_a", $countones(~an_a) <= 1, 1);
    chk("onehot_b", $countones(~an_b) <= 1, 1);
  endtask
  initial begin
    logic [31:0] rd;
    logic [7:0] rp, re;
    ma = '{div: 4, blank: 1, p: 0, d: '0, dp: '0, en: '0, an: 8'hFF, seg: 8'hFF, fd: 1'b0};
    mb = '{div: 2, blank: 0, p: 0, d: '0, dp: '0, en: '0, an: 8'hFF, seg: 8'hFF, fd: 1'b0};
    repeat (3) cyc(1'b1, 32'h76543210, 8'h00, 8'hFF);
    repeat (64) cyc(1'b0, 32'h76543210, 8'h00, 8'hFF);
    repeat (64) cyc(1'b0, 32'hFEDCBA98, 8'h01, 8'h81);
    repeat (45) cyc(1'b0, 32'h0, 8'h00, 8'hFF);
    repeat (70) cyc(1'b0, 32'h11111111, 8'h00, 8'hFF);
    repeat (22) cyc(1'b0, 32'h22222222, 8'h10, 8'hFF);
    cyc(1'b1, 32'h22222222, 8'h10, 8'hFF);
    repeat (40) cyc(1'b0, 32'h33333333, 8'h10, 8'hFF);
    repeat (64) cyc(1'b0, 32'h00000305, 8'h00, 8'hFF);
    repeat (64) cyc(1'b0, 32'h0, 8'hFF, 8'hFF);
    rd = $urandom; rp = 8'($urandom); re = 8'hFF;
    repeat (2500) begin
      if ($urandom_range(0, 15) == 0) begin
        rd = $urandom_range(0, 3) == 0 ? ($urandom & 32'h0000FFFF) : $urandom;
        rp = 8'($urandom);
        re = $urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom);
      end
      cyc($urandom_range(0, 199) == 0, rd, rp, re);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
